// File: rtl/rsa_op_sequencer.sv
// Sequences the RSA core through keygen (start/fin1), key load (start1) and exponentiation (start2/finish).
// Optional RSA_SEQ_TIMEOUT_EN aborts a stalled keygen/exponentiation wait with resp_err.
module rsa_op_sequencer #(
    parameter int DATA_W         = 16,
    parameter int PRIME_W        = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_msg,
    input  logic [PRIME_W-1:0] req_p,
    input  logic [PRIME_W-1:0] req_q,
    input  logic               req_reuse_key,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_data,
    output logic [DATA_W-1:0]  resp_n,
    output logic [PRIME_W-1:0] resp_ekey,
    output logic [DATA_W-1:0]  resp_dkey,
    output logic               resp_err,
    output logic [DATA_W-1:0]  core_input,
    output logic [PRIME_W-1:0] core_p,
    output logic [PRIME_W-1:0] core_q,
    output logic               core_start,
    output logic               core_start1,
    output logic               core_start2,
    input  logic [DATA_W-1:0]  core_output,
    input  logic [DATA_W-1:0]  core_n,
    input  logic [PRIME_W-1:0] core_ekey,
    input  logic [DATA_W-1:0]  core_dkey,
    input  logic               core_fin1,
    input  logic               core_finish
);
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W   = $clog2(GAP_EFF + 1);

    typedef enum logic [2:0] {IDLE, KEYGEN, LOAD, GAP, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic               first;
    logic [GAP_W-1:0]   gap_cnt;
    logic               key_cached;
    logic [PRIME_W-1:0] cached_p, cached_q;
    logic               accept, reuse_hit, keygen_done, run_done, timeout, timed_out;

    assign accept      = req_valid && (state == IDLE);
    assign reuse_hit   = req_reuse_key && key_cached && (req_p == cached_p) && (req_q == cached_q);
    // The core's done levels are only trusted after our own start pulse has been seen.
    assign keygen_done = (state == KEYGEN) && !first && core_fin1;
    assign run_done    = (state == RUN) && !first && core_finish;
    assign timed_out   = timeout && !keygen_done && !run_done;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign timeout = ((state == KEYGEN) || (state == RUN)) && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            resp_err <= 1'b0;
        end else begin
            if ((state == KEYGEN || state == RUN) && !keygen_done && !run_done)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (accept)
                resp_err <= 1'b0;
            else if (timed_out)
                resp_err <= 1'b1;
        end
    end
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            first   <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            first   <= (state_nxt != state);
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        core_start  = 1'b0;
        core_start1 = 1'b0;
        core_start2 = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = reuse_hit ? LOAD : KEYGEN;
            end
            KEYGEN: begin
                core_start = first;
                if (keygen_done)    state_nxt = LOAD;
                else if (timed_out) state_nxt = DONE;
            end
            LOAD: begin
                core_start1 = 1'b1;
                state_nxt   = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_EFF - 1)) state_nxt = RUN;
            end
            RUN: begin
                core_start2 = first;
                if (run_done || timed_out) state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_input <= '0;
            core_p     <= '0;
            core_q     <= '0;
            resp_data  <= '0;
            resp_n     <= '0;
            resp_ekey  <= '0;
            resp_dkey  <= '0;
            key_cached <= 1'b0;
            cached_p   <= '0;
            cached_q   <= '0;
        end else begin
            if (accept) begin
                core_input <= req_msg;
                core_p     <= req_p;
                core_q     <= req_q;
            end
            if (keygen_done) begin
                resp_n     <= core_n;
                resp_ekey  <= core_ekey;
                resp_dkey  <= core_dkey;
                key_cached <= 1'b1;
                cached_p   <= core_p;
                cached_q   <= core_q;
            end
            if (run_done) resp_data <= core_output;
            if (timed_out) begin
                resp_data  <= '0;
                key_cached <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rsa_op_sequencer.sv
// Directed bench for rsa_op_sequencer with a behavioural RSA core responder (fin1 8 cycles, finish 12 cycles after their pulses).
module tb_rsa_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_reuse_key = 1'b0, resp_ready = 1'b0;
    logic [15:0] req_msg = '0;
    logic [7:0]  req_p = '0, req_q = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [15:0] resp_data, resp_n, resp_dkey, core_input, core_output, core_n, core_dkey;
    logic [7:0]  resp_ekey, core_p, core_q, core_ekey;
    logic        core_start, core_start1, core_start2, core_fin1, core_finish;

    int n_asserts = 0, n_fail = 0;
    int cyc = 0, t_acc = 0;
    int n_start = 0, n_start1 = 0, n_start2 = 0, t_start = 0, t_start1 = 0, t_start2 = 0, multi = 0;
    int kg_cnt = 0, fn_cnt = 0;
    logic kg_done = 1'b0, fn_done = 1'b0, kg_run = 1'b0, fn_run = 1'b0, kg_en = 1'b1, force_fin1 = 1'b0;

    rsa_op_sequencer #(.DATA_W(16), .PRIME_W(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg), .req_p(req_p), .req_q(req_q),
        .req_reuse_key(req_reuse_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_n(resp_n),
        .resp_ekey(resp_ekey), .resp_dkey(resp_dkey), .resp_err(resp_err),
        .core_input(core_input), .core_p(core_p), .core_q(core_q),
        .core_start(core_start), .core_start1(core_start1), .core_start2(core_start2),
        .core_output(core_output), .core_n(core_n), .core_ekey(core_ekey), .core_dkey(core_dkey),
        .core_fin1(core_fin1), .core_finish(core_finish)
    );

    // Core model: key outputs are garbage unless fin1 is high, Output is garbage unless finish is high.
    assign core_fin1   = kg_done | force_fin1;
    assign core_finish = fn_done;
    assign core_n      = core_fin1 ? ({8'd0, core_p} * {8'd0, core_q}) : 16'hBEEF;
    assign core_ekey   = core_fin1 ? 8'd5 : 8'hEE;
    assign core_dkey   = core_fin1 ? 16'd1373 : 16'hCAFE;
    assign core_output = fn_done ? core_input + 16'd1000 : 16'hDEAD;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (core_start) begin
            n_start++; t_start = cyc; kg_done = 1'b0; kg_run = 1'b1; kg_cnt = 0;
        end else if (kg_run) begin
            kg_cnt++;
            if (kg_cnt == 8 && kg_en) begin kg_done = 1'b1; kg_run = 1'b0; end
        end
        if (core_start1) begin n_start1++; t_start1 = cyc; kg_done = 1'b0; end
        if (core_start2) begin
            n_start2++; t_start2 = cyc; fn_done = 1'b0; fn_run = 1'b1; fn_cnt = 0;
        end else if (fn_run) begin
            fn_cnt++;
            if (fn_cnt == 12) begin fn_done = 1'b1; fn_run = 1'b0; end
        end
        if (int'(core_start) + int'(core_start1) + int'(core_start2) > 1) multi++;
    end

    task automatic clear_counts();
        n_start = 0; n_start1 = 0; n_start2 = 0; multi = 0;
    endtask

    task automatic send_req(input logic [15:0] msg, input logic [7:0] p, input logic [7:0] q, input logic reuse);
        @(negedge clk);
        req_valid = 1'b1; req_msg = msg; req_p = p; req_q = q; req_reuse_key = reuse;
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid) ok = 1;
        end
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL %s_resp_timeout: resp_valid=%0b after 200 cycles, required 1", name, resp_valid); end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_asserts++;
        if ({req_ready, resp_valid, resp_err, core_start, core_start1, core_start2} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 100000", {req_ready, resp_valid, resp_err, core_start, core_start1, core_start2});
        end
        n_asserts++;
        if ({core_input, core_p, core_q, resp_data, resp_n, resp_ekey, resp_dkey} !== '0) begin
            n_fail++; $display("FAIL reset_regs: in=%0d p=%0d q=%0d data=%0d n=%0d e=%0d d=%0d required all 0",
                core_input, core_p, core_q, resp_data, resp_n, resp_ekey, resp_dkey);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_keygen();
        clear_counts();
        send_req(16'd1256, 8'd67, 8'd53, 1'b0);
        wait_resp("keygen");
        n_asserts++; if (cyc - t_acc !== 28) begin n_fail++; $display("FAIL keygen_latency: got %0d required 28", cyc - t_acc); end
        n_asserts++; if ({n_start, n_start1, n_start2} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL keygen_pulses: start=%0d start1=%0d start2=%0d required 1 each", n_start, n_start1, n_start2); end
        n_asserts++; if (t_start - t_acc !== 1) begin n_fail++; $display("FAIL keygen_start_pos: got %0d required 1", t_start - t_acc); end
        n_asserts++; if (t_start1 - t_start !== 9) begin n_fail++; $display("FAIL keygen_start1_pos: got %0d required 9", t_start1 - t_start); end
        n_asserts++; if (t_start2 - t_start1 !== 5) begin n_fail++; $display("FAIL keygen_gap: got %0d required 5", t_start2 - t_start1); end
        n_asserts++; if (resp_n !== 16'd3551) begin n_fail++; $display("FAIL keygen_resp_n: got %0d required 3551", resp_n); end
        n_asserts++; if (resp_ekey !== 8'd5 || resp_dkey !== 16'd1373) begin
            n_fail++; $display("FAIL keygen_keys: got e=%0d d=%0d required e=5 d=1373", resp_ekey, resp_dkey); end
        n_asserts++; if (resp_data !== 16'd2256) begin n_fail++; $display("FAIL keygen_data: got %0d required 2256", resp_data); end
        n_asserts++; if (resp_err !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL keygen_done_flags: err=%0b ready=%0b required 0 0", resp_err, req_ready); end
        n_asserts++; if (multi !== 0) begin n_fail++; $display("FAIL keygen_overlap: got %0d required 0", multi); end
        release_resp();
        n_asserts++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL keygen_release: ready=%0b valid=%0b required 1 0", req_ready, resp_valid); end
    endtask

    task automatic test_reuse();
        clear_counts();
        send_req(16'd100, 8'd67, 8'd53, 1'b1);
        wait_resp("reuse");
        n_asserts++; if (n_start !== 0) begin n_fail++; $display("FAIL reuse_no_start: got %0d required 0", n_start); end
        n_asserts++; if (t_start1 - t_acc !== 1) begin n_fail++; $display("FAIL reuse_start1_pos: got %0d required 1", t_start1 - t_acc); end
        n_asserts++; if (cyc - t_acc !== 19) begin n_fail++; $display("FAIL reuse_latency: got %0d required 19", cyc - t_acc); end
        n_asserts++; if (resp_ekey !== 8'd5 || resp_dkey !== 16'd1373 || resp_n !== 16'd3551) begin
            n_fail++; $display("FAIL reuse_keys: got e=%0d d=%0d n=%0d required 5 1373 3551", resp_ekey, resp_dkey, resp_n); end
        n_asserts++; if (resp_data !== 16'd1100) begin n_fail++; $display("FAIL reuse_data: got %0d required 1100", resp_data); end
        release_resp();
    endtask

    task automatic test_hold_resp();
        clear_counts();
        send_req(16'd500, 8'd67, 8'd53, 1'b1);
        wait_resp("hold");
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_msg = 16'd777; req_p = 8'd67; req_q = 8'd53; req_reuse_key = 1'b1;
            @(negedge clk);
            n_asserts++;
            if (resp_valid !== 1'b1 || resp_data !== 16'd1500 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_stable_%0d: valid=%0b data=%0d ready=%0b required 1 1500 0", i, resp_valid, resp_data, req_ready);
            end
        end
        n_asserts++; if (core_input !== 16'd500) begin n_fail++; $display("FAIL hold_ignored_req: core_input=%0d required 500", core_input); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_asserts++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: ready=%0b valid=%0b required 1 0", req_ready, resp_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        n_asserts++; if (core_input !== 16'd777 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_accept: core_input=%0d ready=%0b required 777 0", core_input, req_ready); end
        wait_resp("hold2");
        n_asserts++; if (resp_data !== 16'd1777) begin n_fail++; $display("FAIL hold_second_data: got %0d required 1777", resp_data); end
        release_resp();
    endtask

    task automatic test_reset_mid();
        clear_counts();
        send_req(16'd42, 8'd67, 8'd53, 1'b1);
        repeat (2) @(negedge clk);
        n_asserts++; if (n_start1 !== 1 || n_start2 !== 0) begin
            n_fail++; $display("FAIL midrst_in_gap: start1=%0d start2=%0d required 1 0", n_start1, n_start2); end
        #1 rst_n = 1'b0;
        #1;
        n_asserts++;
        if ({req_ready, resp_valid, core_start, core_start1, core_start2} !== 5'b10000 ||
            {core_input, core_p, resp_n, resp_dkey, resp_data} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: ctrl=%b in=%0d p=%0d n=%0d d=%0d data=%0d required 10000 and zeros",
                {req_ready, resp_valid, core_start, core_start1, core_start2}, core_input, core_p, resp_n, resp_dkey, resp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        send_req(16'd10, 8'd67, 8'd53, 1'b1);
        wait_resp("midrst");
        n_asserts++; if (n_start !== 1) begin n_fail++; $display("FAIL midrst_keygen_again: start=%0d required 1", n_start); end
        n_asserts++; if (resp_data !== 16'd1010 || resp_n !== 16'd3551) begin
            n_fail++; $display("FAIL midrst_result: data=%0d n=%0d required 1010 3551", resp_data, resp_n); end
        release_resp();
    endtask

    task automatic test_fin1_early();
        force_fin1 = 1'b1;
        repeat (3) @(negedge clk);
        clear_counts();
        send_req(16'd7, 8'd11, 8'd13, 1'b0);
        wait_resp("early");
        n_asserts++; if (t_start1 - t_start !== 2) begin n_fail++; $display("FAIL early_keygen_len: got %0d required 2", t_start1 - t_start); end
        n_asserts++; if ({n_start, n_start1, n_start2} !== {32'd1, 32'd1, 32'd1} || multi !== 0) begin
            n_fail++; $display("FAIL early_pulses: start=%0d start1=%0d start2=%0d overlap=%0d required 1 1 1 0", n_start, n_start1, n_start2, multi); end
        n_asserts++; if (cyc - t_acc !== 21) begin n_fail++; $display("FAIL early_latency: got %0d required 21", cyc - t_acc); end
        n_asserts++; if (resp_n !== 16'd143 || resp_data !== 16'd1007) begin
            n_fail++; $display("FAIL early_result: n=%0d data=%0d required 143 1007", resp_n, resp_data); end
        force_fin1 = 1'b0;
        release_resp();
    endtask

`ifdef RSA_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        kg_en = 1'b0;
        clear_counts();
        send_req(16'd9, 8'd5, 8'd7, 1'b0);
        wait_resp("timeout");
        n_asserts++; if (cyc - t_start !== 16) begin n_fail++; $display("FAIL timeout_pos: got %0d required 16", cyc - t_start); end
        n_asserts++; if (resp_err !== 1'b1 || resp_data !== 16'd0 || n_start1 !== 0) begin
            n_fail++; $display("FAIL timeout_resp: err=%0b data=%0d start1=%0d required 1 0 0", resp_err, resp_data, n_start1); end
        release_resp();
        kg_en = 1'b1;
        clear_counts();
        send_req(16'd9, 8'd5, 8'd7, 1'b1);
        wait_resp("timeout2");
        n_asserts++; if (n_start !== 1 || resp_err !== 1'b0 || resp_n !== 16'd35) begin
            n_fail++; $display("FAIL timeout_recover: start=%0d err=%0b n=%0d required 1 0 35", n_start, resp_err, resp_n); end
        release_resp();
    endtask
`endif

    initial begin
        test_reset();
        test_keygen();
        test_reuse();
        test_hold_resp();
        test_reset_mid();
        test_fin1_early();
`ifdef RSA_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
